// File: rtl/cellrv32_bus_keeper.sv
// Bus keeper for the shared peripheral bus: tracks each switch access, forwards device
// responses, raises a bus error when no device answers in time, and logs the first fault.
module cellrv32_bus_keeper #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] bus_addr_i,
  input  logic        bus_src_i,
  input  logic        bus_re_i,
  input  logic        bus_we_i,
  input  logic        dev_ack_i,
  input  logic        dev_err_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        err_valid_o,
  output logic [31:0] err_addr_o,
  output logic        err_src_o,
  output logic        err_rw_o,
  output logic        err_timeout_o,
  input  logic        err_clr_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic          src_q, src_d;
  logic          rw_q, rw_d;
  logic          timeout_q, timeout_d;
  logic          log_valid_q, log_valid_d;
  logic [31:0]   log_addr_q, log_addr_d;
  logic          log_src_q, log_src_d;
  logic          log_rw_q, log_rw_d;
  logic          log_timeout_q, log_timeout_d;

  logic pending, req;

  always_comb begin
    pending = (state_q == PENDING);
    req     = bus_re_i | bus_we_i;
    ack_o   = dev_ack_i & pending & ~dev_err_i;
    err_o   = (dev_err_i & pending) | timeout_q;

    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    src_d         = src_q;
    rw_d          = rw_q;
    timeout_d     = 1'b0;
    log_valid_d   = log_valid_q;
    log_addr_d    = log_addr_q;
    log_src_d     = log_src_q;
    log_rw_d      = log_rw_q;
    log_timeout_d = log_timeout_q;

    // A new request always restarts tracking, even if it abandons or overlaps the old access.
    if (req) begin
      state_d = PENDING;
      cnt_d   = '0;
      addr_d  = bus_addr_i;
      src_d   = bus_src_i;
      rw_d    = bus_we_i;
    end else if (pending) begin
      if (dev_ack_i | dev_err_i) begin
        state_d = IDLE;
      end else if (cnt_q == CNT_LAST) begin
        state_d   = IDLE;
        timeout_d = 1'b1;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // The log still sees the tracked access here; a coincident request only lands next cycle.
    if (err_o && (!log_valid_q || err_clr_i)) begin
      log_valid_d   = 1'b1;
      log_addr_d    = addr_q;
      log_src_d     = src_q;
      log_rw_d      = rw_q;
      log_timeout_d = timeout_q;
    end else if (err_clr_i) begin
      log_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      src_q         <= 1'b0;
      rw_q          <= 1'b0;
      timeout_q     <= 1'b0;
      log_valid_q   <= 1'b0;
      log_addr_q    <= '0;
      log_src_q     <= 1'b0;
      log_rw_q      <= 1'b0;
      log_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      src_q         <= src_d;
      rw_q          <= rw_d;
      timeout_q     <= timeout_d;
      log_valid_q   <= log_valid_d;
      log_addr_q    <= log_addr_d;
      log_src_q     <= log_src_d;
      log_rw_q      <= log_rw_d;
      log_timeout_q <= log_timeout_d;
    end
  end

  assign busy_o        = pending;
  assign err_valid_o   = log_valid_q;
  assign err_addr_o    = log_addr_q;
  assign err_src_o     = log_src_q;
  assign err_rw_o      = log_rw_q;
  assign err_timeout_o = log_timeout_q;

endmodule

// File: tb/tb_cellrv32_bus_keeper.sv
// Scoreboard bench for cellrv32_bus_keeper: stimulus queues expected ack/err responses
// with their cycle; a negedge monitor pops and compares whenever the DUT responds.
module tb_cellrv32_bus_keeper;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [31:0] bus_addr_i = '0;
  logic        bus_src_i = 1'b0;
  logic        bus_re_i = 1'b0;
  logic        bus_we_i = 1'b0;
  logic        dev_ack_i = 1'b0;
  logic        dev_err_i = 1'b0;
  logic        err_clr_i = 1'b0;
  logic        ack_o, err_o, busy_o, err_valid_o, err_src_o, err_rw_o, err_timeout_o;
  logic [31:0] err_addr_o;

  typedef struct {
    int cyc;
    bit is_err;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  cellrv32_bus_keeper #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .bus_addr_i(bus_addr_i), .bus_src_i(bus_src_i),
    .bus_re_i(bus_re_i), .bus_we_i(bus_we_i),
    .dev_ack_i(dev_ack_i), .dev_err_i(dev_err_i),
    .ack_o(ack_o), .err_o(err_o), .busy_o(busy_o),
    .err_valid_o(err_valid_o), .err_addr_o(err_addr_o), .err_src_o(err_src_o),
    .err_rw_o(err_rw_o), .err_timeout_o(err_timeout_o), .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Response monitor: every ack_o/err_o must match the head of the queue in cycle and kind.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n_vec++; n_err++;
      $display("[TB] FAIL missed_resp: expected %s at cycle %0d, no response observed (now %0d)",
               exp_q[0].is_err ? "err" : "ack", exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    if (ack_o || err_o) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("[TB] FAIL unexpected_resp: cycle %0d ack=%0b err=%0b, required none",
                 cyc, ack_o, err_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || {ack_o, err_o} != (e.is_err ? 2'b01 : 2'b10)) begin
          n_err++;
          $display("[TB] FAIL resp: cycle %0d ack=%0b err=%0b, required cycle %0d ack=%0b err=%0b",
                   cyc, ack_o, err_o, e.cyc, !e.is_err, e.is_err);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic expect_resp(input int at, input bit is_err);
    exp_t e;
    e.cyc = at;
    e.is_err = is_err;
    exp_q.push_back(e);
  endtask

  // One clock cycle of inputs, driven just after the rising edge, pulses cleared afterwards.
  task automatic apply_stimulus(input logic re, input logic we, input logic [31:0] addr,
                                input logic src, input logic ack, input logic err,
                                input logic clr);
    bus_re_i = re; bus_we_i = we; bus_addr_i = addr; bus_src_i = src;
    dev_ack_i = ack; dev_err_i = err; err_clr_i = clr;
    @(posedge clk_i); #1;
    bus_re_i = 0; bus_we_i = 0; bus_addr_i = '0; bus_src_i = 0;
    dev_ack_i = 0; dev_err_i = 0; err_clr_i = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    int t0;
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    repeat (3) @(posedge clk_i);
    #1;
    check_output("rst_busy", busy_o, 0);
    check_output("rst_err_valid", err_valid_o, 0);
    check_output("rst_err_addr", err_addr_o, 0);
    rstn_i = 1'b1;
    idle(2);

    // Read acked two cycles after the request
    t0 = cyc;
    apply_stimulus(1, 0, 32'h8000_0010, 0, 0, 0, 0);
    check_output("t1_busy_t0p1", busy_o, 1);
    apply_stimulus(0, 0, '0, 0, 0, 0, 0);
    expect_resp(cyc, 0);
    apply_stimulus(0, 0, '0, 0, 1, 0, 0);
    check_output("t1_busy_t0p3", busy_o, 0);
    check_output("t1_err_valid", err_valid_o, 0);
    idle(2);

    // Unanswered write times out with a single err pulse at T0+5
    t0 = cyc;
    expect_resp(t0 + TO + 1, 1);
    apply_stimulus(0, 1, 32'hFFFF_FE00, 1, 0, 0, 0);
    idle(TO + 1);
    check_output("t2_err_valid", err_valid_o, 1);
    check_output("t2_err_addr", err_addr_o, 32'hFFFF_FE00);
    check_output("t2_err_src", err_src_o, 1);
    check_output("t2_err_rw", err_rw_o, 1);
    check_output("t2_err_timeout", err_timeout_o, 1);
    idle(2);
    apply_stimulus(0, 0, '0, 0, 0, 0, 1);
    check_output("t2_clr", err_valid_o, 0);

    // Ack and err together: error wins and is logged as a device error
    apply_stimulus(1, 0, 32'h1234_5670, 0, 0, 0, 0);
    expect_resp(cyc, 1);
    apply_stimulus(0, 0, '0, 0, 1, 1, 0);
    check_output("t3_err_valid", err_valid_o, 1);
    check_output("t3_err_timeout", err_timeout_o, 0);
    check_output("t3_err_addr", err_addr_o, 32'h1234_5670);
    check_output("t3_err_rw", err_rw_o, 0);
    idle(1);

    // Second fault must not overwrite the held record
    t0 = cyc;
    expect_resp(t0 + TO + 1, 1);
    apply_stimulus(1, 0, 32'hA000_0004, 1, 0, 0, 0);
    idle(TO + 1);
    check_output("t4_hold_addr", err_addr_o, 32'h1234_5670);
    check_output("t4_hold_timeout", err_timeout_o, 0);
    check_output("t4_hold_src", err_src_o, 0);
    // Clear coincident with a third error: the new error is logged
    apply_stimulus(0, 1, 32'hB000_0008, 0, 0, 0, 0);
    expect_resp(cyc, 1);
    apply_stimulus(0, 0, '0, 0, 0, 1, 1);
    check_output("t4_clr_err_valid", err_valid_o, 1);
    check_output("t4_clr_err_addr", err_addr_o, 32'hB000_0008);
    check_output("t4_clr_err_rw", err_rw_o, 1);
    apply_stimulus(0, 0, '0, 0, 0, 0, 1);
    check_output("t4_clr2", err_valid_o, 0);

    // Ack in the request cycle and ack after the timeout are both dropped
    t0 = cyc;
    expect_resp(t0 + TO + 1, 1);
    apply_stimulus(1, 0, 32'hC000_0000, 0, 1, 0, 0);
    idle(TO + 2);
    apply_stimulus(0, 0, '0, 0, 1, 0, 0);
    idle(1);
    check_output("t5_log_addr", err_addr_o, 32'hC000_0000);
    check_output("t5_log_valid", err_valid_o, 1);

    // Ack plus new request, then reset mid-access: nothing pending, log wiped, no pulse
    apply_stimulus(1, 0, 32'hD000_0000, 0, 0, 0, 0);
    expect_resp(cyc, 0);
    apply_stimulus(1, 0, 32'hD000_0004, 1, 1, 0, 0);
    check_output("t6_busy_before_rst", busy_o, 1);
    rstn_i = 1'b0;
    #1;
    check_output("t6_busy", busy_o, 0);
    check_output("t6_err_valid", err_valid_o, 0);
    check_output("t6_err_addr", err_addr_o, 0);
    check_output("t6_ack", ack_o, 0);
    check_output("t6_err", err_o, 0);
    idle(2);
    rstn_i = 1'b1;
    idle(TO + 4);
    check_output("t6_busy_after", busy_o, 0);

    n_vec += exp_q.size();
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_err++;
      $display("[TB] FAIL leftover_resp: required %s at cycle %0d, never seen",
               e.is_err ? "err" : "ack", e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
